// File: rtl/uart_pkg.sv
// Shared definitions for the RS232 echo path: ASCII control codes, the echo
// FSM state type and a saturating byte counter helper.
package uart_pkg;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GUARD   = 2'd1,
      LF_WAIT = 2'd2
   } echo_state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/uart_echo_buffer_if.sv
// Receiver/transmitter handshake bundle between the RS232 core and the echo
// buffer. The RS232 side uses the master modport, the echo buffer the slave.
interface uart_echo_buffer_if #(
   parameter int DATA_WIDTH = 8
);

   // rx_valid: one-cycle pulse per received word, rx_data valid in that cycle,
   // no backpressure. tx_en: one-cycle strobe issued only after tx_ready was
   // seen high; tx_data is held from the strobe until the next strobe.
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic                  tx_ready;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_en;

   modport master (
      output rx_data,
      output rx_valid,
      output tx_ready,
      input  tx_data,
      input  tx_en
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  tx_ready,
      output tx_data,
      output tx_en
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a wrap bit on each pointer so full and empty are
// distinguishable; head word is presented combinationally on data_out.
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    pop,
   input  logic [DATA_WIDTH-1:0]   data_in,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0]           wr_ptr;
   logic [AW:0]           rd_ptr;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  pop_ok;
   logic                  push_ok;

   // A push into a full FIFO is legal only when the head leaves in the same cycle.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= data_in;
   end

   assign data_out = mem[rd_ptr[AW-1:0]];
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign level    = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_echo_buffer.sv
// Echoes received words back to the transmitter through a FIFO, optionally
// expanding CR into CR LF, and tracks words lost to a full FIFO.
module uart_echo_buffer
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int CRLF_EN    = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   uart_echo_buffer_if.slave       bus,
   input  logic                    crlf_mode,
   input  logic                    overflow_clr,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic                    overflow,
   output logic [7:0]              drop_count,
   output echo_state_t             state
);

   localparam bit CRLF_OK = (CRLF_EN != 0) && (DATA_WIDTH == 8);
   localparam logic [DATA_WIDTH-1:0] CR_WORD = DATA_WIDTH'(ASCII_CR);
   localparam logic [DATA_WIDTH-1:0] LF_WORD = DATA_WIDTH'(ASCII_LF);

   echo_state_t           state_q;
   echo_state_t           state_d;
   logic                  tx_en_q;
   logic                  tx_en_d;
   logic [DATA_WIDTH-1:0] tx_data_q;
   logic [DATA_WIDTH-1:0] tx_data_d;
   logic                  lf_pending_q;
   logic                  lf_pending_d;
   logic                  crlf_active;

   logic                  push;
   logic                  pop;
   logic                  full;
   logic                  empty;
   logic                  drop;
   logic [DATA_WIDTH-1:0] head;

   assign crlf_active = CRLF_OK && crlf_mode;
   assign push        = bus.rx_valid && (!full || pop);
   assign drop        = bus.rx_valid && full && !pop;

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .data_in  (bus.rx_data),
      .data_out (head),
      .full     (full),
      .empty    (empty),
      .level    (fifo_level)
   );

   // crlf_mode is only looked at when a word is popped; LF_WAIT completes regardless.
   always_comb begin
      state_d      = state_q;
      tx_en_d      = 1'b0;
      tx_data_d    = tx_data_q;
      lf_pending_d = lf_pending_q;
      pop          = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty && bus.tx_ready) begin
               pop          = 1'b1;
               tx_data_d    = head;
               tx_en_d      = 1'b1;
               lf_pending_d = crlf_active && (head == CR_WORD);
               state_d      = GUARD;
            end
         end
         GUARD: begin
            state_d = lf_pending_q ? LF_WAIT : IDLE;
         end
         LF_WAIT: begin
            if (bus.tx_ready) begin
               tx_data_d    = LF_WORD;
               tx_en_d      = 1'b1;
               lf_pending_d = 1'b0;
               state_d      = GUARD;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         tx_en_q      <= 1'b0;
         tx_data_q    <= '0;
         lf_pending_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         tx_en_q      <= tx_en_d;
         tx_data_q    <= tx_data_d;
         lf_pending_q <= lf_pending_d;
      end
   end

   // A clear wins over a drop in the same cycle, so that drop is never counted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow   <= 1'b0;
         drop_count <= 8'd0;
      end else if (overflow_clr) begin
         overflow   <= 1'b0;
         drop_count <= 8'd0;
      end else if (drop) begin
         overflow   <= 1'b1;
         drop_count <= sat_inc8(drop_count);
      end
   end

   assign bus.tx_en   = tx_en_q;
   assign bus.tx_data = tx_data_q;
   assign state       = state_q;

endmodule

// File: doc/uart_echo_buffer.md
# uart_echo_buffer

Parametrised byte-stream echo engine between the RS232 receiver and transmitter ports in the top level. Received words go into an internal FIFO and drain to the transmitter under the TX_ready/en_TX handshake, so back-to-back received bytes are not lost while the transmitter is busy. An optional CR→CR LF expansion mode adds a second transmit for carriage returns. Overflow status and a drop counter are exported for LEDs and debug.

## Interface
- DATA_WIDTH, 8, width of rx/tx words
- DEPTH, 16, FIFO entries; power of two, ≥2
- CRLF_EN, 1, synthesise CR→CR LF expansion logic; 0 ties expansion off
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- rx_data  in  DATA_WIDTH  received word, valid with rx_valid
- rx_valid  in  1  single-cycle pulse per received word (RS232 hasRX)
- tx_ready  in  1  transmitter idle; RS232 drops it on the cycle after tx_en
- tx_data  out  DATA_WIDTH  word to transmit, stable while tx_en high and until next tx_en
- tx_en  out  1  single-cycle transmit strobe (RS232 en_TX)
- crlf_mode  in  1  runtime enable for CR→CR LF; ignored if CRLF_EN=0 or DATA_WIDTH≠8
- overflow_clr  in  1  synchronous clear of overflow and drop_count
- fifo_level  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: a word was dropped because the FIFO was full
- drop_count  out  8  dropped words, saturating at 255

## Operation
- Reset: tx_en=0, tx_data=0, fifo_level=0, overflow=0, drop_count=0, FSM=IDLE, lf_pending=0; FIFO contents undefined.
- Write: rx_valid accepted if not full, or if full and a pop occurs in the same cycle. Otherwise the word is dropped, overflow<=1, drop_count increments (holds at 255).
- overflow_clr takes priority over a same-cycle drop: both fields go to 0 and that drop is not counted.
- TX FSM, all outputs registered:
  - IDLE: if FIFO non-empty and tx_ready, pop head, tx_data<=head, tx_en<=1. lf_pending<=(head==8'h0D && crlf_mode effective). Go to GUARD.
  - GUARD: one cycle, tx_en=0, tx_ready ignored. Go to LF_WAIT if lf_pending, else IDLE.
  - LF_WAIT: when tx_ready, tx_data<=8'h0A, tx_en<=1, lf_pending<=0, go to GUARD. FIFO is not popped. Incoming rx_valid is still written.
- crlf_mode is sampled only at pop time. A change during LF_WAIT does not cancel a pending LF.
- Empty FIFO in IDLE: no tx_en. Pointers wrap modulo DEPTH. Full is tracked with an extra pointer bit.
- Order is preserved exactly. No word is duplicated.

## Timing
- rx_valid at edge t into an empty FIFO, with IDLE and tx_ready=1: tx_en is high in the cycle after edge t+1 (2-cycle latency).
- Minimum spacing between tx_en pulses is 2 cycles (GUARD). In practice spacing is set by tx_ready.
- fifo_level updates on the edge after a push/pop. A simultaneous push and pop leaves it unchanged.
- Reset mid-transmit: tx_en is deasserted immediately. A pending LF and the FIFO contents are discarded.

## Structure
- Shared package uart_pkg:
  - ASCII_CR (8'h0D) and ASCII_LF (8'h0A) constants.
  - Enum echo_state_t {IDLE, GUARD, LF_WAIT}.
- Sub-module sync_fifo (DATA_WIDTH, DEPTH) provides push/pop/full/empty/level.
- The FSM, overflow logic and CRLF logic live in uart_echo_buffer.

## Test plan
- Single byte 8'h41 with tx_ready=1 → one tx_en exactly 2 cycles after rx_valid, tx_data=8'h41, fifo_level returns to 0.
- tx_ready held 0; push 16 bytes 0x00..0x0F, then 3 more → fifo_level=16, overflow=1, drop_count=3. Release tx_ready → 0x00..0x0F emitted in order.
- crlf_mode=1; push 8'h0D, 8'h42 → tx sequence 0x0D, 0x0A, 0x42. With crlf_mode=0 → 0x0D, 0x42.
- FIFO full with rx_valid coincident with a pop → word accepted, drop_count unchanged, fifo_level stays 16.
- 300 drops then overflow_clr → drop_count saturates at 255, then both fields read 0. overflow_clr coincident with a drop → result is 0.
- Assert rst during LF_WAIT → tx_en=0 and fifo_level=0 immediately. No LF is sent after reset release.
